// File: rtl/ps2_kbd_tx.sv
// Device-side PS/2 keyboard transmitter: queues key events and sends them as set-2 frames (E0/F0 prefixes).
// Define PS2TX_OVF_EN to add a sticky 'ovf' output that flags strobes dropped while the FIFO is full.
module ps2_kbd_tx #(
  parameter int CLKDIV  = 1280,
  parameter int GAP     = 2560,
  parameter int FIFO_AW = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       strb,
  input  logic       make,
  input  logic       ext,
  input  logic [7:0] code,
  output logic       full,
  output logic       busy,
  output logic [1:0] ps2
`ifdef PS2TX_OVF_EN
  ,
  output logic       ovf
`endif
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int MAXC  = (CLKDIV > GAP) ? CLKDIV : GAP;
  localparam int CW    = $clog2(MAXC + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKDIV - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_BITH, S_BITL, S_GAP} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [9:0]       r_mem [DEPTH];
  logic [FIFO_AW:0] r_wptr;
  logic [FIFO_AW:0] r_rptr;
  logic [9:0]       r_entry;
  logic             r_e0_done;
  logic             r_f0_done;
  logic             r_code_done;
  logic [10:0]      r_frame;
  logic [3:0]       r_bit;
  logic [CW-1:0]    r_cnt;
  logic [1:0]       r_ps2;
  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic             w_sel_e0;
  logic             w_sel_f0;
  logic [7:0]       w_byte;
  logic             w_half_done;
  logic             w_gap_done;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[FIFO_AW] != r_rptr[FIFO_AW]) &&
                   (r_wptr[FIFO_AW-1:0] == r_rptr[FIFO_AW-1:0]);
  assign w_push  = strb && !w_full;
  assign w_pop   = (r_state == S_IDLE) && !w_empty;

  assign w_half_done = (r_cnt == HALF_LAST);
  assign w_gap_done  = (r_cnt == GAP_LAST);

  // Event storage: array with registered read so it maps onto distributed/block RAM.
  always_ff @(posedge clock) begin
    if (w_push)
      r_mem[r_wptr[FIFO_AW-1:0]] <= {ext, make, code};
    if (w_pop)
      r_entry <= r_mem[r_rptr[FIFO_AW-1:0]];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + 1'b1;
      if (w_pop)
        r_rptr <= r_rptr + 1'b1;
    end
  end

  // Byte order within an event: E0 (extended), then F0 (release), then the scan code.
  assign w_sel_e0 = r_entry[9] && !r_e0_done;
  assign w_sel_f0 = !w_sel_e0 && !r_entry[8] && !r_f0_done;

  always_comb begin
    w_byte = r_entry[7:0];
    if (w_sel_e0)
      w_byte = 8'hE0;
    else if (w_sel_f0)
      w_byte = 8'hF0;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (!w_empty) w_state_next = S_LOAD;
      S_LOAD: w_state_next = S_BITH;
      S_BITH: if (w_half_done) w_state_next = S_BITL;
      S_BITL: if (w_half_done) w_state_next = (r_bit == 4'd10) ? S_GAP : S_BITH;
      S_GAP:  if (w_gap_done) w_state_next = r_code_done ? S_IDLE : S_LOAD;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset)
      r_state <= S_IDLE;
    else
      r_state <= w_state_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_e0_done   <= 1'b0;
      r_f0_done   <= 1'b0;
      r_code_done <= 1'b0;
      r_frame     <= '1;
      r_bit       <= '0;
      r_cnt       <= '0;
    end else begin
      if (w_pop) begin
        r_e0_done   <= 1'b0;
        r_f0_done   <= 1'b0;
        r_code_done <= 1'b0;
      end
      if (r_state == S_LOAD) begin
        if (w_sel_e0)
          r_e0_done <= 1'b1;
        else if (w_sel_f0)
          r_f0_done <= 1'b1;
        else
          r_code_done <= 1'b1;
        // Odd parity: the parity bit makes the 9-bit data+parity field odd-weighted.
        r_frame <= {1'b1, ~^w_byte, w_byte, 1'b0};
        r_bit   <= '0;
      end
      if (r_state == S_BITL && w_half_done && r_bit != 4'd10)
        r_bit <= r_bit + 1'b1;
      if ((r_state == S_BITH || r_state == S_BITL || r_state == S_GAP) &&
          (w_state_next == r_state))
        r_cnt <= r_cnt + 1'b1;
      else
        r_cnt <= '0;
    end
  end

  // Registered bus drive: data only moves together with the clock rising at BITH entry.
  always_ff @(posedge clock) begin
    if (reset)
      r_ps2 <= 2'b11;
    else begin
      case (r_state)
        S_BITH:  r_ps2 <= {r_frame[r_bit], 1'b1};
        S_BITL:  r_ps2 <= {r_frame[r_bit], 1'b0};
        default: r_ps2 <= 2'b11;
      endcase
    end
  end

  assign ps2  = r_ps2;
  assign full = w_full;
  assign busy = !w_empty || (r_state != S_IDLE);

`ifdef PS2TX_OVF_EN
  logic r_ovf;
  always_ff @(posedge clock) begin
    if (reset)
      r_ovf <= 1'b0;
    else if (strb && w_full)
      r_ovf <= 1'b1;
  end
  assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Bench for ps2_kbd_tx: randomized key events, byte-level scoreboard fed by a PS/2 bus decoder.
// Build with PS2TX_OVF_EN defined to also check the overflow flag.
module tb_ps2_kbd_tx;
  localparam int CLKDIV  = 4;
  localparam int GAP     = 8;
  localparam int FIFO_AW = 3;
  localparam int SPACING = 22 * CLKDIV + GAP + 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       strb;
  logic       make;
  logic       ext;
  logic [7:0] code;
  logic       full;
  logic       busy;
  logic [1:0] ps2;
`ifdef PS2TX_OVF_EN
  logic       ovf;
`endif

  ps2_kbd_tx #(.CLKDIV(CLKDIV), .GAP(GAP), .FIFO_AW(FIFO_AW)) dut (
    .clock(clk),
    .reset(reset),
    .strb(strb),
    .make(make),
    .ext(ext),
    .code(code),
    .full(full),
    .busy(busy),
    .ps2(ps2)
`ifdef PS2TX_OVF_EN
    ,
    .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] b;
    bit         first;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: the byte list a key event must produce on the wire.
  task automatic model_event(input bit e, input bit m, input logic [7:0] c);
    bit first = 1'b1;
    if (e) begin
      exp_q.push_back('{8'hE0, first});
      first = 1'b0;
    end
    if (!m) begin
      exp_q.push_back('{8'hF0, first});
      first = 1'b0;
    end
    exp_q.push_back('{c, first});
  endtask

  // Called #1 after a clock edge; returns #1 after the edge that sampled the strobe.
  task automatic strobe(input bit e, input bit m, input logic [7:0] c, input bit accept);
    strb = 1'b1; ext = e; make = m; code = c;
    @(posedge clk); #1;
    strb = 1'b0;
    if (accept) model_event(e, m, c);
  endtask

  task automatic wait_cyc(input longint t);
    while (cyc < t) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_idle(input int budget);
    int i = 0;
    while ((busy || exp_q.size() != 0) && i < budget) begin
      @(posedge clk); #1;
      i++;
    end
    chk("idle_timeout", longint'(i >= budget), 0);
  endtask

  // Bus decoder acting as the receiver: samples data on clk falling edges.
  task automatic monitor();
    logic [1:0]  prev = 2'b11;
    logic [1:0]  cur;
    logic [10:0] bits = '0;
    int          nb = 0;
    bit          in_frame = 1'b0;
    longint      t_hi = 0, t_fall = 0, t_start = 0, t_prev = 0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev = 2'b11; nb = 0; in_frame = 1'b0;
      end else begin
        cur = ps2;
        if (!in_frame && nb == 0 && prev == 2'b11 && cur == 2'b01) begin
          in_frame = 1'b1; t_start = cyc; t_hi = cyc;
        end
        if (prev[0] == 1'b0 && cur[0] == 1'b0 && cur[1] != prev[1])
          chk("data_moved_while_clk_low", longint'(cur[1]), longint'(prev[1]));
        if (prev[0] == 1'b0 && cur[0] == 1'b1) begin
          chk("clk_low_len", cyc - t_fall, CLKDIV);
          t_hi = cyc;
        end
        if (prev[0] == 1'b1 && cur[0] == 1'b0) begin
          chk("falling_edge_in_frame", longint'(in_frame), 1);
          chk("clk_high_len", cyc - t_hi, CLKDIV);
          t_fall = cyc;
          if (in_frame) begin
            bits[nb] = cur[1];
            nb++;
            if (nb == 11) begin
              chk("frame_start_bit", longint'(bits[0]), 0);
              chk("frame_stop_bit", longint'(bits[10]), 1);
              chk("frame_odd_parity", longint'(^bits[9:1]), 1);
              if (exp_q.size() == 0) begin
                chk("unexpected_byte", longint'(bits[8:1]), 256);
              end else begin
                e = exp_q.pop_front();
                chk("byte_value", longint'(bits[8:1]), longint'(e.b));
                if (!e.first)
                  chk("byte_spacing", t_start - t_prev, SPACING);
                $display("byte %02h received (expected %02h)", bits[8:1], e.b);
              end
              t_prev = t_start;
              nb = 0;
              in_frame = 1'b0;
            end
          end
        end
        prev = cur;
      end
    end
  endtask

  logic [7:0] bc [10];
  bit         be [10];
  bit         bm [10];
  longint     n0;

  initial begin
    reset = 1'b1; strb = 1'b0; make = 1'b0; ext = 1'b0; code = '0;
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_ps2", longint'(ps2), 2'b11);
    chk("reset_busy", longint'(busy), 0);
    chk("reset_full", longint'(full), 0);
`ifdef PS2TX_OVF_EN
    chk("reset_ovf", longint'(ovf), 0);
`endif
    @(posedge clk); #1;

    // Single press of 1C: start-bit latency and busy release timing.
    strobe(1'b0, 1'b1, 8'h1C, 1'b1);
    n0 = cyc;
    wait_cyc(n0 + 2);
    chk("lines_high_before_start", longint'(ps2), 2'b11);
    wait_cyc(n0 + 3);
    chk("start_bit_latency", longint'(ps2), 2'b01);
    wait_cyc(n0 + 1 + SPACING - 1);
    chk("busy_before_end", longint'(busy), 1);
    wait_cyc(n0 + 1 + SPACING);
    chk("busy_release", longint'(busy), 0);
    wait_idle(1000);

    // Release of 1C (F0 1C), then extended press of 75 (E0 75).
    strobe(1'b0, 1'b0, 8'h1C, 1'b1);
    wait_idle(1000);
    strobe(1'b1, 1'b1, 8'h75, 1'b1);
    wait_idle(1000);

    // Ten back-to-back strobes: first is popped early, so nine fit and the tenth is dropped.
    for (int i = 0; i < 10; i++) begin
      be[i] = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      bm[i] = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      bc[i] = 8'($urandom_range(1, 255));
    end
    for (int i = 0; i < 10; i++) begin
      strb = 1'b1; ext = be[i]; make = bm[i]; code = bc[i];
      @(posedge clk); #1;
      if (i == 0) n0 = cyc;
      if (i < 9) model_event(be[i], bm[i], bc[i]);
      if (i == 7) chk("full_at_7", longint'(full), 0);
      if (i == 8) chk("full_at_8", longint'(full), 1);
`ifdef PS2TX_OVF_EN
      if (i == 8) chk("ovf_before_drop", longint'(ovf), 0);
      if (i == 9) chk("ovf_after_drop", longint'(ovf), 1);
`endif
      if (i == 9) chk("full_after_drop", longint'(full), 1);
    end
    strb = 1'b0;

    // Strobe on the edge that pops event 2 (FIFO still full: dropped), then one cycle later (accepted).
    wait_cyc(n0 + 1 + SPACING);
    strb = 1'b1; ext = 1'b0; make = 1'b1; code = 8'hA5;
    @(posedge clk); #1;
    code = 8'h5A;
    @(posedge clk); #1;
    strb = 1'b0;
    model_event(1'b0, 1'b1, 8'h5A);
    chk("full_refilled", longint'(full), 1);
    wait_idle(5000);

    // Reset in the middle of bit 5 aborts the frame.
    strobe(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'b1);
    n0 = cyc;
    wait_cyc(n0 + 44);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_ps2", longint'(ps2), 2'b11);
    chk("abort_busy", longint'(busy), 0);
    chk("abort_full", longint'(full), 0);
`ifdef PS2TX_OVF_EN
    chk("abort_ovf", longint'(ovf), 0);
`endif
    reset = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    strobe(1'b0, 1'b1, 8'h29, 1'b1);
    wait_idle(1000);

    // Random bursts of events.
    for (int r = 0; r < 6; r++) begin
      int k = $urandom_range(1, 5);
      for (int j = 0; j < k; j++)
        strobe(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'b1);
      wait_idle(3000);
    end

    chk("leftover_expected", longint'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
